// File: rtl/iig_line_integrator.sv
// Streaming 2-D integral-image generator: row-running accumulator plus a one-line buffer of previous-row integrals.
// Define IIG_SQ_EN to add oSqData, the integral of the squared pixel stream.
module iig_line_integrator #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 320,
    parameter int unsigned IMG_H = 240,
    parameter int unsigned COL_W = 9,
    parameter int unsigned ROW_W = 8,
    parameter int unsigned OUT_W = 25
) (
    input  logic                           iClk,
    input  logic                           iReset_n,
    input  logic                           iFrame_start,
    input  logic                           iValid,
    input  logic [PIX_W-1:0]               iData,
    output logic                           oValid,
    output logic [OUT_W-1:0]               oData,
    output logic [COL_W-1:0]               oCol,
    output logic [ROW_W-1:0]               oRow,
    output logic                           oFrame_done
`ifdef IIG_SQ_EN
    ,
    output logic [2*PIX_W+COL_W+ROW_W-1:0] oSqData
`endif
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col, cur_col, nxt_col;
    logic [ROW_W-1:0] row, cur_row, nxt_row;
    logic [OUT_W-1:0] row_acc, cur_acc, rs, up, sum;
    logic [OUT_W-1:0] line_buf [IMG_W];
    logic             col_end, row_end;

    // A frame-start pulse acts on the beat it accompanies, so the counters seen by
    // this beat are the cleared ones rather than the registered ones.
    always_comb begin
        cur_col = iFrame_start ? '0 : col;
        cur_row = iFrame_start ? '0 : row;
        cur_acc = iFrame_start ? '0 : row_acc;
        col_end = (cur_col == COL_LAST);
        row_end = (cur_row == ROW_LAST);
        rs      = cur_acc + {{(OUT_W-PIX_W){1'b0}}, iData};
        up      = (cur_row == '0) ? '0 : line_buf[cur_col];
        sum     = rs + up;
        nxt_col = col_end ? '0 : cur_col + COL_W'(1);
        nxt_row = cur_row;
        if (col_end) begin
            nxt_row = row_end ? '0 : cur_row + ROW_W'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            col         <= '0;
            row         <= '0;
            row_acc     <= '0;
            oValid      <= 1'b0;
            oFrame_done <= 1'b0;
            oData       <= '0;
            oCol        <= '0;
            oRow        <= '0;
        end else begin
            oValid      <= iValid;
            oFrame_done <= iValid && col_end && row_end;
            if (iValid) begin
                col     <= nxt_col;
                row     <= nxt_row;
                row_acc <= col_end ? '0 : rs;
                oData   <= sum;
                oCol    <= cur_col;
                oRow    <= cur_row;
            end else if (iFrame_start) begin
                col     <= '0;
                row     <= '0;
                row_acc <= '0;
            end
        end
    end

    // Line buffer carries no reset; stale contents are masked on row 0.
    always_ff @(posedge iClk) begin
        if (iReset_n && iValid) begin
            line_buf[cur_col] <= sum;
        end
    end

`ifdef IIG_SQ_EN
    localparam int unsigned SQ_W = 2*PIX_W + COL_W + ROW_W;

    logic [2*PIX_W-1:0] pix_sq;
    logic [SQ_W-1:0]    sq_acc, sq_cur_acc, sq_rs, sq_up, sq_sum;
    logic [SQ_W-1:0]    sq_buf [IMG_W];

    always_comb begin
        pix_sq     = {{PIX_W{1'b0}}, iData} * {{PIX_W{1'b0}}, iData};
        sq_cur_acc = iFrame_start ? '0 : sq_acc;
        sq_rs      = sq_cur_acc + {{(SQ_W-2*PIX_W){1'b0}}, pix_sq};
        sq_up      = (cur_row == '0) ? '0 : sq_buf[cur_col];
        sq_sum     = sq_rs + sq_up;
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            sq_acc  <= '0;
            oSqData <= '0;
        end else if (iValid) begin
            sq_acc  <= col_end ? '0 : sq_rs;
            oSqData <= sq_sum;
        end else if (iFrame_start) begin
            sq_acc  <= '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset_n && iValid) begin
            sq_buf[cur_col] <= sq_sum;
        end
    end
`endif

endmodule

// File: tb/tb_iig_line_integrator.sv
// Scoreboard bench: small-frame DUT checked beat-by-beat against a direct-summation model,
// plus a default-size DUT checked on its full-frame result.
module tb_iig_line_integrator;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 8;
    localparam int CW = 2;
    localparam int RW = 2;
    localparam int OW = 16;
    localparam int SW = 2*PW + CW + RW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0, start = 1'b0, valid = 1'b0;
    logic [PW-1:0] data = '0;
    logic          o_valid, o_done;
    logic [OW-1:0] o_data;
    logic [CW-1:0] o_col;
    logic [RW-1:0] o_row;

    logic          b_rst_n = 1'b0, b_valid = 1'b0;
    logic [7:0]    b_data = '0;
    logic          b_o_valid, b_o_done;
    logic [24:0]   b_o_data;
    logic [8:0]    b_o_col;
    logic [7:0]    b_o_row;
`ifdef IIG_SQ_EN
    logic [SW-1:0] o_sq;
    logic [32:0]   b_o_sq;
`endif

    iig_line_integrator #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .COL_W(CW), .ROW_W(RW), .OUT_W(OW)) dut (
        .iClk(clk), .iReset_n(rst_n), .iFrame_start(start), .iValid(valid), .iData(data),
        .oValid(o_valid), .oData(o_data), .oCol(o_col), .oRow(o_row), .oFrame_done(o_done)
`ifdef IIG_SQ_EN
        , .oSqData(o_sq)
`endif
    );

    iig_line_integrator big (
        .iClk(clk), .iReset_n(b_rst_n), .iFrame_start(1'b0), .iValid(b_valid), .iData(b_data),
        .oValid(b_o_valid), .oData(b_o_data), .oCol(b_o_col), .oRow(b_o_row), .oFrame_done(b_o_done)
`ifdef IIG_SQ_EN
        , .oSqData(b_o_sq)
`endif
    );

    typedef struct {
        longint d;
        longint sq;
        int     col;
        int     row;
        int     done;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;
    int   pix[H][W];
    int   pos = 0;
    int   exp_valid = 0, got_valid = 0, exp_done = 0, got_done = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: store the pixel at its raster position, then sum the rectangle directly.
    task automatic beat(input bit st, input bit v, input int d);
        exp_t e;
        int   x, y;
        @(negedge clk);
        start = st;
        valid = v;
        data  = PW'(d);
        if (st) pos = 0;
        if (v) begin
            x = pos % W;
            y = pos / W;
            pix[y][x] = d;
            e.d = 0;
            e.sq = 0;
            for (int j = 0; j <= y; j++)
                for (int i = 0; i <= x; i++) begin
                    e.d  += pix[j][i];
                    e.sq += pix[j][i] * pix[j][i];
                end
            e.col  = x;
            e.row  = y;
            e.done = (pos == W*H - 1) ? 1 : 0;
            q.push_back(e);
            exp_valid++;
            exp_done += e.done;
            pos = (pos + 1) % (W*H);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) beat(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_done", o_done, 0);
        check("rst_data", o_data, 0);
        check("rst_col", o_col, 0);
        check("rst_row", o_row, 0);
`ifdef IIG_SQ_EN
        check("rst_sq", o_sq, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        pos = 0;
    endtask

    // Monitor for the small DUT.
    initial begin : monitor
        exp_t   e;
        longint last_d = 0, last_c = 0, last_r = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                last_d = 0; last_c = 0; last_r = 0;
            end else if (o_valid) begin
                got_valid++;
                if (o_done) got_done++;
                if (q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("data", o_data, e.d);
                    check("col", o_col, e.col);
                    check("row", o_row, e.row);
                    check("frame_done", o_done, e.done);
`ifdef IIG_SQ_EN
                    check("sq", o_sq, e.sq);
`endif
                end
                last_d = o_data; last_c = o_col; last_r = o_row;
            end else begin
                check("idle_done", o_done, 0);
                check("hold_data", o_data, last_d);
                check("hold_col", o_col, last_c);
                check("hold_row", o_row, last_r);
            end
        end
    end

    int     b_cnt = 0, b_dones = 0, b_done_col = -1, b_done_row = -1;
    longint b_last_d = 0, b_last_sq = 0;
    initial begin : big_monitor
        forever begin
            @(posedge clk);
            #1;
            if (b_rst_n && b_o_valid) begin
                b_cnt++;
                b_last_d = b_o_data;
`ifdef IIG_SQ_EN
                b_last_sq = b_o_sq;
`endif
                if (b_o_done) begin
                    b_dones++;
                    b_done_col = b_o_col;
                    b_done_row = b_o_row;
                end
            end
        end
    end

    task automatic run_small();
        do_reset();
        // all ones, back-to-back
        for (int i = 0; i < W*H; i++) beat(0, 1, 1);
        // ramp col+4*row
        for (int i = 0; i < W*H; i++) beat(0, 1, i);
        idle(2);
        // all ones with random gaps
        for (int i = 0; i < W*H; i++) begin
            idle($urandom_range(0, 3));
            beat(0, 1, 1);
        end
        idle(2);
        // abort after 6 beats via reset, then value 2
        for (int i = 0; i < 6; i++) beat(0, 1, $urandom_range(0, 255));
        do_reset();
        for (int i = 0; i < W*H; i++) beat(0, 1, 2);
        // two frames back-to-back, then restart on beat 3 of frame 3
        for (int i = 0; i < 2*W*H; i++) beat(0, 1, $urandom_range(0, 255));
        beat(0, 1, $urandom_range(0, 255));
        beat(0, 1, $urandom_range(0, 255));
        beat(1, 1, $urandom_range(0, 255));
        for (int i = 1; i < W*H; i++) beat(0, 1, $urandom_range(0, 255));
        // mid-frame start without a valid beat
        for (int i = 0; i < 7; i++) beat(0, 1, $urandom_range(0, 255));
        beat(1, 0, 0);
        for (int i = 0; i < W*H; i++) beat(0, 1, $urandom_range(0, 255));
        // random mix of gaps, restarts and data
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            beat($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 255));
        end
        idle(4);
        check("queue_empty", q.size(), 0);
        check("valid_count", got_valid, exp_valid);
        check("done_count", got_done, exp_done);
    endtask

    task automatic run_big();
        @(negedge clk);
        b_rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        b_rst_n = 1'b1;
        for (int i = 0; i < 320*240; i++) begin
            @(negedge clk);
            b_valid = 1'b1;
            b_data  = 8'd255;
        end
        @(negedge clk);
        b_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("big_count", b_cnt, 76800);
        check("big_final", b_last_d, longint'(255) * 320 * 240);
        check("big_dones", b_dones, 1);
        check("big_done_col", b_done_col, 319);
        check("big_done_row", b_done_row, 239);
`ifdef IIG_SQ_EN
        check("big_final_sq", b_last_sq, longint'(65025) * 76800);
`endif
    endtask

    initial begin : watchdog
        #3_000_000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin : main
        fork
            run_small();
            run_big();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
